mac_rx_client: RTL

- Consumer end of the tri-mode MAC RX client interface.
- Answers `mac_rxda_i` with `mac_rxrqrd_o`, captures 32-bit words framed by SOP/EOP/DV, and writes them into the packet buffer feeding the AXI side.
- Each accepted packet yields one length/base descriptor; malformed or oversized packets are drained and discarded.

---
 rtl/mac_rx_pkg.sv | 30 +++
 rtl/mac_rx_client.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mac_rx_pkg.sv
// Shared types and helpers for the MAC RX client receive path.
package mac_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCommit,
    StDrop
  } mac_rx_state_e;

  // Valid-byte encoding carried with the EOP word.
  localparam logic [1:0] BenFour  = 2'b00;
  localparam logic [1:0] BenOne   = 2'b01;
  localparam logic [1:0] BenTwo   = 2'b10;
  localparam logic [1:0] BenThree = 2'b11;

  // Number of valid bytes (1..4) in the final word of a packet.
  function automatic logic [2:0] ben_bytes(input logic [1:0] ben);
    logic [2:0] bytes;
    bytes = 3'd4;
    case (ben)
      BenOne:   bytes = 3'd1;
      BenTwo:   bytes = 3'd2;
      BenThree: bytes = 3'd3;
      default:  bytes = 3'd4;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/mac_rx_client.sv
// Consumer side of the MAC RX client interface: requests packets, writes their words into the
// packet buffer and publishes one base/length descriptor per good packet. Bad packets are drained
// and counted.
module mac_rx_client
  import mac_rx_pkg::*;
#(
  parameter int unsigned ADDR_W        = 15,
  parameter logic [15:0] MAX_PKT_WORDS = 16'd5000,
  parameter logic [15:0] TIMEOUT_CYC   = 16'd1024
) (
  input  logic              mac_clk_i,
  input  logic              mac_rst_i,
  input  logic [31:0]       mac_rxd_i,
  input  logic [1:0]        mac_ben_i,
  input  logic              mac_rxda_i,
  input  logic              mac_rxsop_i,
  input  logic              mac_rxeop_i,
  input  logic              mac_rxdv_i,
  output logic              mac_rxrqrd_o,
  input  logic [ADDR_W:0]   buf_free_i,
  output logic              buf_wr_en_o,
  output logic [ADDR_W-1:0] buf_wr_addr_o,
  output logic [31:0]       buf_wr_data_o,
  output logic              pkt_valid_o,
  input  logic              pkt_ready_i,
  output logic [ADDR_W-1:0] pkt_base_o,
  output logic [15:0]       pkt_len_o,
  output logic [15:0]       drop_cnt_o
);

  mac_rx_state_e     state_q, state_d;
  logic              rqrd_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [ADDR_W-1:0] wr_ptr_q;   // base of the packet in flight
  logic [15:0]       offset_q;   // words accepted so far
  logic [1:0]        ben_q;
  logic [15:0]       tmo_q;
  logic              pkt_valid_q;
  logic [ADDR_W-1:0] pkt_base_q;
  logic [15:0]       pkt_len_q;
  logic [15:0]       drop_cnt_q;

  logic        free_ok;
  logic        in_rx;
  logic        tmo_hit;
  logic        bad_word;
  logic        wr_accept;
  logic        drop_done;
  logic [15:0] commit_len;

  assign free_ok    = (32'(buf_free_i) >= 32'(MAX_PKT_WORDS));
  assign in_rx      = (state_q == StRecv) || (state_q == StDrop);
  assign tmo_hit    = in_rx && !mac_rxdv_i && (tmo_q == TIMEOUT_CYC - 16'd1);
  // First word must open the packet, later words must not, and the size cap is hard.
  assign bad_word   = ((offset_q == 16'd0) && !mac_rxsop_i) ||
                      ((offset_q != 16'd0) && mac_rxsop_i) ||
                      (offset_q == MAX_PKT_WORDS);
  assign commit_len = ((offset_q - 16'd1) << 2) + 16'(ben_bytes(ben_q));

  // Next-state decode plus write-accept and drop-completion strobes.
  always_comb begin
    state_d   = state_q;
    wr_accept = 1'b0;
    drop_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mac_rxda_i && !pkt_valid_q && free_ok) state_d = StRecv;
      end
      StRecv: begin
        if (mac_rxdv_i) begin
          if (bad_word) begin
            if (mac_rxeop_i) begin
              drop_done = 1'b1;
              state_d   = StIdle;
            end else begin
              state_d = StDrop;
            end
          end else begin
            wr_accept = 1'b1;
            if (mac_rxeop_i) state_d = StCommit;
          end
        end else if (tmo_hit) begin
          drop_done = 1'b1;
          state_d   = StIdle;
        end
      end
      StCommit: state_d = StIdle;
      StDrop: begin
        if ((mac_rxdv_i && mac_rxeop_i) || tmo_hit) begin
          drop_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, buffer write pipeline, descriptor and counters.
  always_ff @(posedge mac_clk_i or negedge mac_rst_i) begin
    if (!mac_rst_i) begin
      state_q     <= StIdle;
      rqrd_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_ptr_q    <= '0;
      offset_q    <= '0;
      ben_q       <= '0;
      tmo_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_base_q  <= '0;
      pkt_len_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rqrd_q  <= (state_d == StRecv) || (state_d == StDrop);
      wr_en_q <= wr_accept;
      if (wr_accept) begin
        wr_addr_q <= wr_ptr_q + ADDR_W'(offset_q);
        wr_data_q <= mac_rxd_i;
      end
      if (state_q == StIdle) begin
        offset_q <= '0;
      end else if (wr_accept) begin
        offset_q <= offset_q + 16'd1;
      end
      if (wr_accept && mac_rxeop_i) ben_q <= mac_ben_i;
      tmo_q <= (in_rx && !mac_rxdv_i && !tmo_hit) ? tmo_q + 16'd1 : '0;
      // The pointer only moves on commit, so a drop implicitly rewinds to the base.
      if (state_q == StCommit) begin
        pkt_valid_q <= 1'b1;
        pkt_base_q  <= wr_ptr_q;
        pkt_len_q   <= commit_len;
        wr_ptr_q    <= wr_ptr_q + ADDR_W'(offset_q);
      end else if (pkt_ready_i) begin
        pkt_valid_q <= 1'b0;
      end
      if (drop_done && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign mac_rxrqrd_o  = rqrd_q;
  assign buf_wr_en_o   = wr_en_q;
  assign buf_wr_addr_o = wr_addr_q;
  assign buf_wr_data_o = wr_data_q;
  assign pkt_valid_o   = pkt_valid_q;
  assign pkt_base_o    = pkt_base_q;
  assign pkt_len_o     = pkt_len_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
